wave_player: RTL and testbench

Downstream consumer of the wave start-address selector. On a go strobe it latches the selected 8-bit start address and walks a segment table in the wave memory. Each table entry gives a drive level and a hold duration. It presents the current level to the head/motor driver until it reaches an entry flagged last. Its outputs are the drive-level and status signals consumed by the output driver stage.

---
 rtl/wave_player.sv | 144 ++++++++++++++
 tb/tb_wave_player.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_player.sv
// Wave segment player: walks a {last, level, dur} table from a latched start address
// and drives the level for (dur+1)*TICK_DIV cycles per entry.
module wave_player #(
   parameter int TICK_DIV = 16,
   parameter int MAX_SEG  = 64
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        wave_go,
   input  logic        wave_stop,
   input  logic [7:0]  wave_start_addr,
   output logic        wave_rd_en,
   output logic [7:0]  wave_rd_addr,
   input  logic [15:0] wave_rd_data,
   output logic [6:0]  drv_level,
   output logic        busy,
   output logic        done,
   output logic        wave_err,
   output logic [2:0]  dbg_state
);

   localparam int TW = $clog2(TICK_DIV);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_LOAD  = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    ptr_q, ptr_d;
   logic [7:0]    seg_cnt_q, seg_cnt_d;
   logic [7:0]    dur_cnt_q, dur_cnt_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          last_q, last_d;
   logic [6:0]    level_q, level_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          tick_wrap;

   assign tick_wrap = (tick_cnt_q == TW'(TICK_DIV - 1));

   // Stop beats go; go restarts from any state; otherwise the table walk advances.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      seg_cnt_d  = seg_cnt_q;
      dur_cnt_d  = dur_cnt_q;
      tick_cnt_d = tick_cnt_q;
      last_d     = last_q;
      level_d    = level_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      if (wave_stop) begin
         if (state_q != S_IDLE) begin
            state_d = S_IDLE;
            level_d = 7'h00;
            busy_d  = 1'b0;
         end
      end else if (wave_go) begin
         state_d   = S_FETCH;
         ptr_d     = wave_start_addr;
         seg_cnt_d = 8'h00;
         err_d     = 1'b0;
         busy_d    = 1'b1;
      end else begin
         case (state_q)
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_LOAD;
            S_LOAD: begin
               state_d    = S_HOLD;
               last_d     = wave_rd_data[15];
               level_d    = wave_rd_data[14:8];
               dur_cnt_d  = wave_rd_data[7:0];
               tick_cnt_d = '0;
            end
            S_HOLD: begin
               if (!tick_wrap) begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end else begin
                  tick_cnt_d = '0;
                  if (dur_cnt_q != 8'h00) begin
                     dur_cnt_d = dur_cnt_q - 8'd1;
                  end else if (last_q) begin
                     state_d = S_IDLE;
                     level_d = 7'h00;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else if (seg_cnt_q == 8'(MAX_SEG - 1)) begin
                     state_d = S_IDLE;
                     level_d = 7'h00;
                     busy_d  = 1'b0;
                     err_d   = 1'b1;
                  end else begin
                     state_d   = S_FETCH;
                     ptr_d     = ptr_q + 8'd1;
                     seg_cnt_d = seg_cnt_q + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         ptr_q      <= 8'h00;
         seg_cnt_q  <= 8'h00;
         dur_cnt_q  <= 8'h00;
         tick_cnt_q <= '0;
         last_q     <= 1'b0;
         level_q    <= 7'h00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         seg_cnt_q  <= seg_cnt_d;
         dur_cnt_q  <= dur_cnt_d;
         tick_cnt_q <= tick_cnt_d;
         last_q     <= last_d;
         level_q    <= level_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign wave_rd_en   = (state_q == S_FETCH);
   assign wave_rd_addr = ptr_q;
   assign drv_level    = level_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign wave_err     = err_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_wave_player.sv
// Bench for wave_player: directed vector table, hand-written corner sequences and
// random waves, all compared per cycle against a trace built from the wave rules.
module tb_wave_player;

   localparam int TICK_DIV = 16;
   localparam int MAX_SEG  = 4;
   localparam int W        = 19;   // {rd_en, rd_addr[7:0], level[6:0], busy, done, err}

   logic        clk;
   logic        rstn;
   logic        wave_go;
   logic        wave_stop;
   logic [7:0]  wave_start_addr;
   logic        wave_rd_en;
   logic [7:0]  wave_rd_addr;
   logic [15:0] wave_rd_data;
   logic [6:0]  drv_level;
   logic        busy;
   logic        done;
   logic        wave_err;
   logic [2:0]  dbg_state;

   wave_player #(.TICK_DIV(TICK_DIV), .MAX_SEG(MAX_SEG)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .wave_go         (wave_go),
      .wave_stop       (wave_stop),
      .wave_start_addr (wave_start_addr),
      .wave_rd_en      (wave_rd_en),
      .wave_rd_addr    (wave_rd_addr),
      .wave_rd_data    (wave_rd_data),
      .drv_level       (drv_level),
      .busy            (busy),
      .done            (done),
      .wave_err        (wave_err),
      .dbg_state       (dbg_state)
   );

   // ---------------- clock / reset / memory ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [15:0] mem [256];

   // Synchronous-read table memory: data appears the cycle after the strobe and holds.
   always @(posedge clk) begin
      if (wave_rd_en) wave_rd_data <= mem[wave_rd_addr];
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation time limit reached, got no end, required end of test");
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   logic         exp_err_end;
   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc_idx, act_reads, act_term, act_done;

   typedef struct {
      logic [7:0] start;
      int         nreads;
      int         term;
      int         ndone;
      logic       err;
   } vec_t;
   vec_t vecs[4];

   // Expected per-cycle trace from T+1 to the termination cycle, derived from the
   // segment rules: 3 gap cycles holding the old level, (dur+1)*TICK_DIV at the new one.
   function automatic void build_trace(input logic [7:0] start, input logic [6:0] init_lvl);
      logic [7:0]  a;
      logic [6:0]  prev;
      logic [15:0] e;
      int          seg;
      bit          fin;
      a    = start;
      prev = init_lvl;
      seg  = 0;
      fin  = 1'b0;
      exp_q.delete();
      while (!fin) begin
         e = mem[a];
         exp_q.push_back({1'b1, a, prev, 3'b100});
         repeat (2) exp_q.push_back({1'b0, 8'h00, prev, 3'b100});
         for (int i = 0; i < (int'(e[7:0]) + 1) * TICK_DIV; i++)
            exp_q.push_back({1'b0, 8'h00, e[14:8], 3'b100});
         prev = e[14:8];
         seg++;
         if (e[15]) begin
            exp_q.push_back({1'b0, 8'h00, 7'h00, 3'b010});
            exp_err_end = 1'b0;
            fin = 1'b1;
         end else if (seg == MAX_SEG) begin
            exp_q.push_back({1'b0, 8'h00, 7'h00, 3'b001});
            exp_err_end = 1'b1;
            fin = 1'b1;
         end else begin
            a = a + 8'd1;
         end
      end
   endfunction

   task automatic check_vec(input string name, input logic [W-1:0] exp, input int idx);
      logic [W-1:0] act;
      logic [W-1:0] e;
      act = {wave_rd_en, wave_rd_addr, drv_level, busy, done, wave_err};
      e   = exp;
      if (!e[18]) begin
         act[17:10] = 8'h00;
         e[17:10]   = 8'h00;
      end
      n_checks++;
      if (act !== e) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got rd_en=%0b addr=%02h lvl=%02h busy=%0b done=%0b err=%0b, required rd_en=%0b addr=%02h lvl=%02h busy=%0b done=%0b err=%0b",
                  name, idx, act[18], act[17:10], act[9:3], act[2], act[1], act[0],
                  e[18], e[17:10], e[9:3], e[2], e[1], e[0]);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic go_pulse(input logic [7:0] a);
      wave_go         = 1'b1;
      wave_start_addr = a;
      @(negedge clk);
      wave_go   = 1'b0;
      cyc_idx   = 0;
      act_reads = 0;
      act_term  = 0;
      act_done  = 0;
   endtask

   task automatic check_cycles(input string name, input int n);
      logic [W-1:0] e;
      int k;
      k = 0;
      while (exp_q.size() > 0 && (n < 0 || k < n)) begin
         e = exp_q.pop_front();
         k++;
         cyc_idx++;
         check_vec(name, e, cyc_idx);
         if (wave_rd_en) act_reads++;
         if ((done || wave_err) && act_term == 0) act_term = cyc_idx;
         if (done) act_done++;
         @(negedge clk);
      end
   endtask

   task automatic run_wave(input string name, input logic [7:0] start);
      build_trace(start, 7'h00);
      go_pulse(start);
      check_cycles(name, -1);
      check_vec({name, "_after"}, {16'h0000, 2'b00, exp_err_end}, cyc_idx + 1);
   endtask

   // ---------------- test ----------------
   initial begin
      logic [7:0] rs;
      int         n;

      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h06] = {1'b1, 7'h55, 8'd2};
      mem[8'h10] = {1'b0, 7'h10, 8'd0};
      mem[8'h11] = {1'b0, 7'h20, 8'd0};
      mem[8'h12] = {1'b1, 7'h30, 8'd0};
      mem[8'hFF] = {1'b0, 7'h11, 8'd1};
      mem[8'h00] = {1'b1, 7'h22, 8'd0};
      mem[8'h03] = {1'b1, 7'h33, 8'd1};
      for (int i = 0; i < 5; i++) mem[8'h40 + i] = {1'b0, 7'h41 + 7'(i), 8'd0};

      vecs[0] = '{8'h06, 1, 52, 1, 1'b0};
      vecs[1] = '{8'h10, 3, 58, 1, 1'b0};
      vecs[2] = '{8'hFF, 2, 55, 1, 1'b0};
      vecs[3] = '{8'h40, 4, 77, 0, 1'b1};

      wave_rd_data    = 16'h0000;
      rstn            = 1'b0;
      wave_go         = 1'b0;
      wave_stop       = 1'b0;
      wave_start_addr = 8'h00;
      repeat (3) @(negedge clk);
      check_vec("reset", '0, 0);
      rstn = 1'b1;
      @(negedge clk);
      check_vec("reset_release", '0, 0);

      // Directed vectors from the table.
      for (int v = 0; v < 4; v++) begin
         run_wave($sformatf("vec%0d", v), vecs[v].start);
         check_int($sformatf("vec%0d_reads", v), act_reads, vecs[v].nreads);
         check_int($sformatf("vec%0d_term", v), act_term, vecs[v].term);
         check_int($sformatf("vec%0d_done", v), act_done, vecs[v].ndone);
         check_int($sformatf("vec%0d_err", v), int'(wave_err), int'(vecs[v].err));
      end

      // Stop while idle leaves the sticky error untouched.
      wave_stop = 1'b1;
      @(negedge clk);
      wave_stop = 1'b0;
      check_vec("stop_idle", {16'h0000, 3'b001}, 0);
      @(negedge clk);
      check_vec("stop_idle_2", {16'h0000, 3'b001}, 1);

      // Retrigger mid-HOLD: new walk from 0x03, level held, no done for the first wave.
      build_trace(8'h00, 7'h00);
      go_pulse(8'h00);
      check_cycles("retrig_first", 8);
      build_trace(8'h03, 7'h22);
      go_pulse(8'h03);
      check_cycles("retrig_second", -1);
      check_int("retrig_reads", act_reads, 1);
      check_int("retrig_done", act_done, 1);

      // Stop together with go mid-wave: idle, level 0, no read.
      build_trace(8'h10, 7'h00);
      go_pulse(8'h10);
      check_cycles("stop_pre", 10);
      wave_stop       = 1'b1;
      wave_go         = 1'b1;
      wave_start_addr = 8'h06;
      @(negedge clk);
      wave_stop = 1'b0;
      wave_go   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_vec("stop_go", '0, i);
         @(negedge clk);
      end

      // Asynchronous reset mid-HOLD, then a normal wave.
      build_trace(8'h06, 7'h00);
      go_pulse(8'h06);
      check_cycles("rst_pre", 10);
      #2 rstn = 1'b0;
      #1 check_vec("async_rst", '0, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      run_wave("post_rst", 8'h06);
      check_int("post_rst_done", act_done, 1);

      // Random waves against the trace model.
      for (int r = 0; r < 6; r++) begin
         n  = $urandom_range(1, 5);
         rs = 8'h80 + 8'(r * 8) + 8'($urandom_range(0, 2));
         for (int i = 0; i < n; i++)
            mem[rs + 8'(i)] = {(i == n - 1), 7'($urandom_range(1, 127)), 8'($urandom_range(0, 2))};
         run_wave($sformatf("rand%0d", r), rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
